// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with trap redirect, circular return-address
// stack and jump-target alignment checking. Drives the instruction ROM address.
`default_nettype none

module pc_unit #(
    parameter int              ADDR_W     = 32,
    parameter int              STEP       = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC   = 'h100,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic              enable,
    input  logic              trapReq,
    input  logic              jumpValid,
    input  logic              callPush,
    input  logic              retPop,
    input  logic [ADDR_W-1:0] addrJump,
    output logic [ADDR_W-1:0] addrOut,
    output logic              rasEmpty,
    output logic              rasFull,
    output logic              misaligned,
    output logic              rasUnderflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
    localparam logic [CNT_W-1:0]  DEPTH_V    = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mis_q, mis_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jump_aligned;
    logic              jump_mis;
    logic [PTR_W-1:0]  ptr_dec;

    assign pc_inc       = pc_q + STEP_V;
    assign jump_aligned = addrJump & ~ALIGN_MASK;
    assign jump_mis     = |(addrJump & ALIGN_MASK);
    // ptr_q is the next write slot, so the top of stack sits one below it
    assign ptr_dec      = ptr_q - PTR_W'(1);

    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        mis_d = 1'b0;
        unf_d = 1'b0;
        ras_d = ras_q;
        if (trapReq) begin
            pc_d  = TRAP_VEC;
            cnt_d = '0;
        end else if (!enable) begin
            pc_d = pc_q;
        end else if (retPop) begin
            if (cnt_q != '0) begin
                pc_d  = ras_q[ptr_dec];
                ptr_d = ptr_dec;
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                pc_d  = jump_aligned;
                mis_d = jump_mis;
                unf_d = 1'b1;
            end
        end else if (jumpValid) begin
            pc_d  = jump_aligned;
            mis_d = jump_mis;
            if (callPush) begin
                // Full stack: overwrite the oldest slot, count saturates
                ras_d[ptr_q] = pc_inc;
                ptr_d        = ptr_q + PTR_W'(1);
                if (cnt_q != DEPTH_V) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            pc_q  <= RESET_ADDR;
            ptr_q <= '0;
            cnt_q <= '0;
            mis_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            mis_q <= mis_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage needs no reset: entries are only read when count is nonzero
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign addrOut      = pc_q;
    assign rasEmpty     = (cnt_q == '0);
    assign rasFull      = (cnt_q == DEPTH_V);
    assign misaligned   = mis_q;
    assign rasUnderflow = unf_q;

endmodule

`default_nettype wire
